umi_tx_packer: RTL and testbench



---
 rtl/umi_pkg.sv | 67 ++++++
 rtl/umi_tx_packer_if.sv | 47 ++++
 rtl/umi_encode.sv | 58 +++++
 rtl/umi_tx_packer.sv | 185 ++++++++++++++++++
 tb/tb_umi_tx_packer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : umi_pkg
// Description : Shared UMI opcodes, type codes, packer states and cmd layout.
// Revision    : 1.0 - initial release
// ============================================================================
package umi_pkg;

  localparam int CMD_OPCODE_LSB = 0;
  localparam int CMD_SIZE_LSB   = 8;
  localparam int CMD_USER_LSB   = 12;

  localparam logic [7:0] OP_WRITE_RESPONSE = 8'h01;
  localparam logic [7:0] OP_WRITE_SIGNAL   = 8'h02;
  localparam logic [7:0] OP_WRITE_STREAM   = 8'h03;
  localparam logic [7:0] OP_WRITE_ACK      = 8'h04;
  localparam logic [7:0] OP_WRITE_NORMAL   = 8'h05;
  localparam logic [7:0] OP_READ           = 8'h08;
  localparam logic [7:0] OP_ATOMIC         = 8'h09;

  // Atomic sub-operation lives in opcode[6:4]
  localparam logic [2:0] ATOMIC_SWAP = 3'd0;
  localparam logic [2:0] ATOMIC_ADD  = 3'd1;
  localparam logic [2:0] ATOMIC_AND  = 3'd2;
  localparam logic [2:0] ATOMIC_OR   = 3'd3;
  localparam logic [2:0] ATOMIC_XOR  = 3'd4;
  localparam logic [2:0] ATOMIC_MAX  = 3'd5;
  localparam logic [2:0] ATOMIC_MIN  = 3'd6;

  typedef enum logic [3:0] {
    TYPE_WRITE_NORMAL   = 4'd0,
    TYPE_WRITE_SIGNAL   = 4'd1,
    TYPE_WRITE_ACK      = 4'd2,
    TYPE_WRITE_STREAM   = 4'd3,
    TYPE_WRITE_RESPONSE = 4'd4,
    TYPE_READ           = 4'd5,
    TYPE_ATOMIC_SWAP    = 4'd6,
    TYPE_ATOMIC_ADD     = 4'd7,
    TYPE_ATOMIC_AND     = 4'd8,
    TYPE_ATOMIC_OR      = 4'd9,
    TYPE_ATOMIC_XOR     = 4'd10,
    TYPE_ATOMIC_MAX     = 4'd11,
    TYPE_ATOMIC_MIN     = 4'd12
  } req_type_e;

  localparam logic [3:0] TYPE_LAST = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DST_LO = 3'd2,
    ST_DST_HI = 3'd3,
    ST_SRC_LO = 3'd4,
    ST_SRC_HI = 3'd5,
    ST_DATA   = 3'd6
  } state_e;

  function automatic logic type_illegal(input logic [3:0] t);
    return t > TYPE_LAST;
  endfunction

  function automatic logic [7:0] atomic_opcode(input logic [2:0] sub);
    return {1'b0, sub, OP_ATOMIC[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/umi_tx_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : umi_tx_packer_if
// Description : Request, payload and beat-stream signals of the UMI tx packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface umi_tx_packer_if #(
  parameter int AW = 64
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_type;
  logic [3:0]    req_size;
  logic [19:0]   req_user;
  logic [AW-1:0] req_dstaddr;
  logic [AW-1:0] req_srcaddr;
  logic          req_err;
  logic          data_valid;
  logic          data_ready;
  logic [31:0]   data_in;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   tx_data;
  logic          tx_first;
  logic          tx_last;

  // Host / initiator side
  modport master (
    output req_valid, req_type, req_size, req_user, req_dstaddr, req_srcaddr,
    input  req_ready, req_err,
    output data_valid, data_in,
    input  data_ready,
    input  tx_valid, tx_data, tx_first, tx_last,
    output tx_ready
  );

  // Packer side
  modport slave (
    input  req_valid, req_type, req_size, req_user, req_dstaddr, req_srcaddr,
    output req_ready, req_err,
    input  data_valid, data_in,
    output data_ready,
    output tx_valid, tx_data, tx_first, tx_last,
    input  tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/umi_encode.sv
`default_nettype none
// ============================================================================
// Module      : umi_encode
// Description : Combinational (type, size, user) -> UMI cmd word and packet
//               shape flags.
// Revision    : 1.0 - initial release
// ============================================================================
module umi_encode
  import umi_pkg::*;
(
  input  logic [3:0]  req_type,
  input  logic [3:0]  req_size,
  input  logic [19:0] req_user,
  output logic [31:0] cmd,
  output logic        needs_src,
  output logic        has_data,
  output logic        illegal
);

  logic [7:0] opcode;
  logic [3:0] size_field;

  always_comb begin
    opcode     = 8'h00;
    size_field = req_size;
    needs_src  = 1'b0;
    has_data   = 1'b0;
    case (req_type)
      TYPE_WRITE_NORMAL:   begin opcode = OP_WRITE_NORMAL;   has_data = 1'b1; end
      TYPE_WRITE_SIGNAL:   begin opcode = OP_WRITE_SIGNAL;   has_data = 1'b1; end
      TYPE_WRITE_STREAM:   begin opcode = OP_WRITE_STREAM;   has_data = 1'b1; end
      TYPE_WRITE_RESPONSE: begin opcode = OP_WRITE_RESPONSE; has_data = 1'b1; end
      TYPE_WRITE_ACK: begin
        opcode    = OP_WRITE_ACK;
        has_data  = 1'b1;
        needs_src = 1'b1;
      end
      TYPE_READ: begin
        opcode    = OP_READ;
        needs_src = 1'b1;
      end
      // Atomic type codes are ordered like the opcode[6:4] sub-ops
      TYPE_ATOMIC_SWAP, TYPE_ATOMIC_ADD, TYPE_ATOMIC_AND, TYPE_ATOMIC_OR,
      TYPE_ATOMIC_XOR, TYPE_ATOMIC_MAX, TYPE_ATOMIC_MIN: begin
        opcode     = atomic_opcode(3'(req_type - TYPE_ATOMIC_SWAP));
        size_field = 4'd0;
        needs_src  = 1'b1;
        has_data   = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = type_illegal(req_type);
  assign cmd     = {req_user, size_field, opcode};

endmodule
`default_nettype wire

// File: rtl/umi_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : umi_tx_packer
// Description : Packs one UMI transaction into a 32-bit valid/ready beat stream
//               (cmd, dstaddr, optional srcaddr, payload).
//               Optional: UMI_TX_ERRCNT_EN adds a saturating err_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module umi_tx_packer
  import umi_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic           clk,
  input  logic           reset,
  umi_tx_packer_if.slave bus
`ifdef UMI_TX_ERRCNT_EN
  ,
  output logic [7:0]     err_count
`endif
);

  localparam bit HAS_HI = (AW == 64);

  state_e      state_q, state_d;
  logic [3:0]  type_q, type_d;
  logic [3:0]  size_q, size_d;
  logic [19:0] user_q, user_d;
  logic [63:0] dst_q, dst_d;
  logic [63:0] src_q, src_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_err_q, req_err_d;

  logic [31:0] enc_cmd;
  logic        enc_needs_src;
  logic        enc_has_data;
  logic        enc_illegal;
  logic [3:0]  data_size;
  logic        tx_hs;
  state_e      after_dst;
  state_e      after_src;

  umi_encode u_encode (
    .req_type  (type_q),
    .req_size  (size_q),
    .req_user  (user_q),
    .cmd       (enc_cmd),
    .needs_src (enc_needs_src),
    .has_data  (enc_has_data),
    .illegal   (enc_illegal)
  );

  // Atomic forces the cmd size to 0, so the cmd field is the true beat bound
  assign data_size = enc_cmd[CMD_SIZE_LSB +: 4];
  assign tx_hs     = bus.tx_valid & bus.tx_ready;
  assign after_src = enc_has_data ? ST_DATA : ST_IDLE;
  assign after_dst = enc_needs_src ? ST_SRC_LO : after_src;

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    size_d         = size_q;
    user_d         = user_q;
    dst_d          = dst_q;
    src_d          = src_q;
    cnt_d          = cnt_q;
    req_err_d      = 1'b0;
    bus.req_ready  = 1'b0;
    bus.data_ready = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 32'h0;
    bus.tx_first   = 1'b0;
    bus.tx_last    = 1'b0;

    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            type_d = bus.req_type;
            size_d = bus.req_size;
            user_d = bus.req_user;
            dst_d  = 64'(bus.req_dstaddr);
            src_d  = 64'(bus.req_srcaddr);
            cnt_d  = 4'd0;
            if (type_illegal(bus.req_type)) begin
              req_err_d = 1'b1;
            end else begin
              state_d = ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (enc_illegal) begin
            state_d = ST_IDLE;
          end else begin
            bus.tx_valid = 1'b1;
            bus.tx_first = 1'b1;
            bus.tx_data  = enc_cmd;
            if (tx_hs) state_d = ST_DST_LO;
          end
        end
        ST_DST_LO: begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = dst_q[31:0];
          if (tx_hs) state_d = HAS_HI ? ST_DST_HI : after_dst;
        end
        ST_DST_HI: begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = dst_q[63:32];
          if (tx_hs) state_d = after_dst;
        end
        ST_SRC_LO: begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = src_q[31:0];
          bus.tx_last  = !HAS_HI && !enc_has_data;
          if (tx_hs) state_d = HAS_HI ? ST_SRC_HI : after_src;
        end
        ST_SRC_HI: begin
          bus.tx_valid = 1'b1;
          bus.tx_data  = src_q[63:32];
          bus.tx_last  = !enc_has_data;
          if (tx_hs) state_d = after_src;
        end
        ST_DATA: begin
          bus.tx_valid   = bus.data_valid;
          bus.data_ready = bus.tx_ready;
          bus.tx_data    = bus.data_in;
          bus.tx_last    = (cnt_q == data_size);
          if (tx_hs) begin
            if (cnt_q == data_size) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      type_q    <= 4'd0;
      size_q    <= 4'd0;
      user_q    <= 20'd0;
      dst_q     <= 64'd0;
      src_q     <= 64'd0;
      cnt_q     <= 4'd0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      size_q    <= size_d;
      user_q    <= user_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      req_err_q <= req_err_d;
    end
  end

  assign bus.req_err = req_err_q & ~reset;

`ifdef UMI_TX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (req_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_umi_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_umi_tx_packer
// Description : Self-checking bench for umi_tx_packer (AW=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_tx_packer;
  import umi_pkg::*;

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  size;
    logic [19:0] user;
    logic [63:0] dst;
    logic [63:0] src;
    logic [31:0] exp_cmd;
    bit          exp_src;
    int          exp_data;
    int          mode;   // 0 free-run, 1 random tx_ready, 2 data gaps, 3 DST_HI stall
  } vec_t;

  typedef struct {
    logic [31:0] d;
    bit          first;
    bit          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  beat_t exp_q[$];
  logic        prev_pend = 1'b0;
  logic [31:0] prev_data = 32'h0;
  vec_t vecs[14];

  umi_tx_packer_if #(.AW(64)) bus ();
`ifdef UMI_TX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  umi_tx_packer #(.AW(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef UMI_TX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted beat is popped and compared
  always @(negedge clk) begin
    if (!mon_en || reset) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend) begin
        check("stall_valid_held", 64'(bus.tx_valid), 64'd1);
        check("stall_data_held", 64'(bus.tx_data), 64'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_beat: got 0x%0h expected no beat", bus.tx_data);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", 64'(bus.tx_data), 64'(b.d));
          check("beat_first", 64'(bus.tx_first), 64'(b.first));
          check("beat_last", 64'(bus.tx_last), 64'(b.last));
        end
      end
      prev_pend <= bus.tx_valid & ~bus.tx_ready;
      prev_data <= bus.tx_data;
    end
  end

  task automatic wait_req_ready();
    int guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input vec_t v);
    beat_t       seq[$];
    logic [31:0] words[$];
    beat_t       b;
    int nbeats, di, hs, cyc, stall_left;
    bit tx_hs, d_hs;

    b.first = 1'b0; b.last = 1'b0;
    b.d = v.exp_cmd; b.first = 1'b1; seq.push_back(b); b.first = 1'b0;
    b.d = v.dst[31:0];  seq.push_back(b);
    b.d = v.dst[63:32]; seq.push_back(b);
    if (v.exp_src) begin
      b.d = v.src[31:0];  seq.push_back(b);
      b.d = v.src[63:32]; seq.push_back(b);
    end
    for (int i = 0; i < v.exp_data; i++) begin
      words.push_back($urandom);
      b.d = words[i];
      seq.push_back(b);
    end
    seq[seq.size()-1].last = 1'b1;
    nbeats = seq.size();

    wait_req_ready();
    bus.req_type    = v.typ;
    bus.req_size    = v.size;
    bus.req_user    = v.user;
    bus.req_dstaddr = v.dst;
    bus.req_srcaddr = v.src;
    bus.req_valid   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    foreach (seq[i]) exp_q.push_back(seq[i]);

    di = 0; hs = 0; cyc = 0; stall_left = 3;
    while (hs < nbeats && cyc < 400) begin
      bus.data_in    = (di < v.exp_data) ? words[di] : 32'h0;
      bus.data_valid = (di < v.exp_data) && (v.mode != 2 || $urandom_range(0, 1) == 1);
      case (v.mode)
        1: bus.tx_ready = ($urandom_range(0, 2) != 0);
        3: begin
          bus.tx_ready = !(hs == 2 && stall_left > 0);
          if (!bus.tx_ready) stall_left--;
        end
        default: bus.tx_ready = 1'b1;
      endcase
      @(negedge clk);
      if (cyc == 0) begin
        check("accept_latency_valid", 64'(bus.tx_valid), 64'd1);
        check("accept_latency_first", 64'(bus.tx_first), 64'd1);
      end
      if (!(di < v.exp_data) || hs < nbeats - v.exp_data)
        check("data_ready_held_off", 64'(bus.data_ready), 64'd0);
      tx_hs = bus.tx_valid & bus.tx_ready;
      d_hs  = bus.data_valid & bus.data_ready;
      @(posedge clk); #1;
      if (tx_hs) hs++;
      if (d_hs) di++;
      cyc++;
    end
    if (hs < nbeats) check("packet_timeout", 64'(hs), 64'(nbeats));
    bus.data_valid = 1'b0;
    bus.tx_ready   = 1'b1;
    @(negedge clk);
    check("post_packet_req_ready", 64'(bus.req_ready), 64'd1);
    check("post_packet_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic illegal_req(input logic [3:0] t);
    wait_req_ready();
    bus.req_type  = t;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("illegal_req_err_pulse", 64'(bus.req_err), 64'd1);
    check("illegal_no_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("illegal_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    check("illegal_req_err_one_cycle", 64'(bus.req_err), 64'd0);
    check("illegal_still_no_tx", 64'(bus.tx_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int hs;
    bit seen;

    //          type size user      dst                     src                     cmd           src data mode
    vecs[0]  = '{4'd0,  4'd3,  20'h00ABC, 64'h1_0000_2000,        64'h0,                  32'h00ABC305, 0, 4,  0};
    vecs[1]  = '{4'd5,  4'd0,  20'h00000, 64'h40,                 64'h80,                 32'h00000008, 1, 0,  0};
    vecs[2]  = '{4'd7,  4'd7,  20'h00001, 64'h3_0000_1000,        64'h4_0000_2000,        32'h00001019, 1, 1,  0};
    vecs[3]  = '{4'd2,  4'd1,  20'hFFFFF, 64'hDEAD_BEEF_0000_0010, 64'h0123_4567_89AB_CDEF, 32'hFFFFF104, 1, 2,  1};
    vecs[4]  = '{4'd3,  4'd15, 20'h12345, 64'h10,                 64'h0,                  32'h12345F03, 0, 16, 2};
    vecs[5]  = '{4'd1,  4'd0,  20'h00001, 64'hCAFE_0000_0000_0004, 64'h0,                  32'h00001002, 0, 1,  3};
    vecs[6]  = '{4'd4,  4'd2,  20'h54321, 64'h0000_0007_0000_0100, 64'h0,                  32'h54321201, 0, 3,  1};
    vecs[7]  = '{4'd5,  4'd15, 20'h0000A, 64'h5555_AAAA_1234_5678, 64'h9999_0000_0000_1111, 32'h0000AF08, 1, 0,  3};
    vecs[8]  = '{4'd12, 4'd5,  20'h0000F, 64'h20,                 64'h30,                 32'h0000F069, 1, 1,  2};
    vecs[9]  = '{4'd6,  4'd0,  20'h00000, 64'h1,                  64'h2,                  32'h00000009, 1, 1,  0};
    vecs[10] = '{4'd10, 4'd3,  20'h00002, 64'h100,                64'h200,                32'h00002049, 1, 1,  1};
    vecs[11] = '{4'd8,  4'd0,  20'h00000, 64'h8,                  64'h9,                  32'h00000029, 1, 1,  0};
    vecs[12] = '{4'd9,  4'd1,  20'h00000, 64'hA,                  64'hB,                  32'h00000039, 1, 1,  0};
    vecs[13] = '{4'd11, 4'd2,  20'h00000, 64'hC,                  64'hD,                  32'h00000059, 1, 1,  0};

    bus.req_valid = 1'b0; bus.req_type = 4'd0; bus.req_size = 4'd0; bus.req_user = 20'd0;
    bus.req_dstaddr = 64'd0; bus.req_srcaddr = 64'd0;
    bus.data_valid = 1'b0; bus.data_in = 32'h0; bus.tx_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("reset_tx_data", 64'(bus.tx_data), 64'd0);
    check("reset_tx_first", 64'(bus.tx_first), 64'd0);
    check("reset_tx_last", 64'(bus.tx_last), 64'd0);
    check("reset_data_ready", 64'(bus.data_ready), 64'd0);
    check("reset_req_err", 64'(bus.req_err), 64'd0);
    check("reset_req_ready_idle", 64'(bus.req_ready), 64'd1);
`ifdef UMI_TX_ERRCNT_EN
    check("reset_err_count", 64'(err_count), 64'd0);
`endif
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) send(vecs[i]);

    illegal_req(4'hE);
`ifdef UMI_TX_ERRCNT_EN
    check("err_count_one", 64'(err_count), 64'd1);
`endif
    illegal_req(4'hD);
    illegal_req(4'hF);
`ifdef UMI_TX_ERRCNT_EN
    check("err_count_three", 64'(err_count), 64'd3);
    bus.req_type  = 4'hF;
    bus.req_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("err_count_saturate", 64'(err_count), 64'd255);
    @(posedge clk); #1;
`endif

    // Reset lands on the second of four payload beats
    mon_en = 1'b0;
    wait_req_ready();
    bus.req_type = 4'd0; bus.req_size = 4'd3; bus.req_user = 20'h00077;
    bus.req_dstaddr = 64'h1000; bus.req_srcaddr = 64'h0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.tx_ready   = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 32'h5A5A_0001;
    hs = 0;
    for (int c = 0; c < 50 && hs < 5; c++) begin
      @(negedge clk);
      if (bus.tx_valid && bus.tx_ready) hs++;
      if (hs == 5) reset = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reset_target_beat_reached", 64'(hs), 64'd5);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midpkt_reset_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("midpkt_reset_tx_data", 64'(bus.tx_data), 64'd0);
    check("midpkt_reset_tx_last", 64'(bus.tx_last), 64'd0);
    check("midpkt_reset_data_ready", 64'(bus.data_ready), 64'd0);
    check("midpkt_reset_req_ready", 64'(bus.req_ready), 64'd1);
`ifdef UMI_TX_ERRCNT_EN
    check("midpkt_reset_err_count", 64'(err_count), 64'd0);
`endif
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_valid) seen = 1'b1;
    end
    check("no_beats_after_reset", 64'(seen), 64'd0);
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    send(vecs[1]);
    send(vecs[7]);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
